booth_mac_accum: RTL

Accumulate stage directly downstream of the pipelined radix-4 Booth multiplier (`rad4_booth_pipe`). Consumes a stream of signed products under a valid/ready handshake and sums exactly N_TERMS of them into a wide accumulator. Presents the saturated sum to the next stage under a second valid/ready handshake. Together with the multiplier it forms the MAC datapath for the FIR/dot-product lab experiments.

---
 rtl/booth_mac_pkg.sv | 26 ++
 rtl/booth_mac_accum_sat_clip.sv | 30 +++
 rtl/booth_mac_accum.sv | 106 ++++++++++
 3 files changed

// File: rtl/booth_mac_pkg.sv
// Shared types and helpers for the Booth MAC accumulate stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Signed limits of an ow-bit two's complement result.
    function automatic longint sat_max(input int ow);
        return (longint'(1) <<< (ow - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int ow);
        return -(longint'(1) <<< (ow - 1));
    endfunction

    // The accumulator must hold n products without wrapping, and the
    // narrowed result must fit inside the accumulator.
    function automatic bit widths_ok(input int pw, input int aw, input int ow, input int n);
        return (aw >= pw + $clog2(n)) && (ow <= aw) && (n >= 2);
    endfunction

endpackage

// File: rtl/booth_mac_accum_sat_clip.sv
// Saturating narrower from accumulator width to result width, with clip flag.
// Latency: combinational.
// Backpressure: none.
module sat_clip
    import booth_mac_pkg::*;
#(
    parameter int ACC_WIDTH = 20,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] val,
    output logic                        clip
);

    localparam logic signed [ACC_WIDTH-1:0] LIM_HI = ACC_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] LIM_LO = ACC_WIDTH'(sat_min(OUT_WIDTH));

    always_comb begin
        val  = acc[OUT_WIDTH-1:0];
        clip = 1'b0;
        if (acc > LIM_HI) begin
            val  = LIM_HI[OUT_WIDTH-1:0];
            clip = 1'b1;
        end else if (acc < LIM_LO) begin
            val  = LIM_LO[OUT_WIDTH-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/booth_mac_accum.sv
// Sums N_TERMS signed products and presents the saturated result downstream.
// Latency: sum valid the cycle after the last product is accepted.
// Backpressure: no products accepted while a finished sum waits for sum_ready_i.
module booth_mac_accum
    import booth_mac_pkg::*;
#(
    parameter int PROD_WIDTH = 15,
    parameter int ACC_WIDTH  = 20,
    parameter int OUT_WIDTH  = 16,
    parameter int N_TERMS    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [PROD_WIDTH-1:0]      prod_i,
    input  logic                              prod_valid_i,
    output logic                              prod_ready_o,
    input  logic                              clear_i,
    output logic signed [OUT_WIDTH-1:0]       sum_o,
    output logic                              sum_valid_o,
    input  logic                              sum_ready_i,
    output logic                              sat_o,
    output logic [$clog2(N_TERMS+1)-1:0]      count_o
);

    localparam int  CW        = $clog2(N_TERMS + 1);
    localparam bit  WIDTHS_OK = widths_ok(PROD_WIDTH, ACC_WIDTH, OUT_WIDTH, N_TERMS);

    generate
        if (!WIDTHS_OK) begin : g_bad_widths
            $error("booth_mac_accum: illegal PROD/ACC/OUT width or N_TERMS combination");
        end
    endgenerate

    state_t                       state, state_nxt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic [CW-1:0]                count;
    logic signed [OUT_WIDTH-1:0]  clip_val;
    logic                         clip_flag;
    logic                         accept;
    logic                         last;

    assign prod_ext = ACC_WIDTH'(prod_i);
    assign acc_sum  = acc + prod_ext;
    assign accept   = prod_valid_i && prod_ready_o;
    assign last     = accept && (count == CW'(N_TERMS - 1));
    assign count_o  = count;

    // Narrow the running total including the final product, so the result
    // register captures the complete sum on the accepting edge.
    sat_clip #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat_clip (
        .acc  (acc_sum),
        .val  (clip_val),
        .clip (clip_flag)
    );

    always_comb begin
        state_nxt    = state;
        prod_ready_o = (state == ACCUM) && !clear_i;
        case (state)
            ACCUM: if (last)        state_nxt = HOLD;
            HOLD:  if (sum_ready_i) state_nxt = ACCUM;
            default:                state_nxt = ACCUM;
        endcase
        if (clear_i) state_nxt = ACCUM;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ACCUM;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            count       <= '0;
            sum_o       <= '0;
            sat_o       <= 1'b0;
            sum_valid_o <= 1'b0;
        end else if (clear_i) begin
            acc         <= '0;
            count       <= '0;
            sat_o       <= 1'b0;
            sum_valid_o <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    acc         <= '0;
                    count       <= '0;
                    sum_o       <= clip_val;
                    sat_o       <= clip_flag;
                    sum_valid_o <= 1'b1;
                end else begin
                    acc   <= acc_sum;
                    count <= count + CW'(1);
                end
            end
            if ((state == HOLD) && sum_ready_i) sum_valid_o <= 1'b0;
        end
    end

endmodule
